// File: rtl/glb_pkg.sv
// Shared sizing, requester ids and FSM state encoding for the global-buffer arbiter.
package glb_pkg;

   localparam int NUM_REQ = 4;
   localparam int ADDR_W  = 16;
   localparam int DATA_W  = 32;

   typedef enum logic [1:0] {
      REQ_FILTER = 2'd0,
      REQ_IFMAP  = 2'd1,
      REQ_IPSUM  = 2'd2,
      REQ_OPSUM  = 2'd3
   } req_id_t;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_BURST = 1'b1
   } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// One-hot round-robin pick: first asserted request at or after ptr, searched modulo N.
module rr_arbiter #(
   parameter int N  = 4,
   parameter int PW = 2
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic [N-1:0]  gnt
);

   always_comb begin
      int   idx;
      logic found;
      gnt   = '0;
      found = 1'b0;
      idx   = 0;
      for (int k = 0; k < N; k++) begin
         idx = int'(ptr) + k;
         if (idx >= N) idx = idx - N;
         if (!found && req[PW'(idx)]) begin
            gnt[PW'(idx)] = 1'b1;
            found         = 1'b1;
         end
      end
   end

endmodule

// File: rtl/glb_arbiter.sv
// Global-buffer port arbiter: round-robin between bursts, burst lock on the owner,
// combinational GLB drive and a one-cycle read-return tag.
module glb_arbiter
   import glb_pkg::*;
#(
   parameter  int NUM_REQ = glb_pkg::NUM_REQ,
   parameter  int ADDR_W  = glb_pkg::ADDR_W,
   parameter  int DATA_W  = glb_pkg::DATA_W,
   localparam int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [NUM_REQ-1:0]               req_valid,
   output logic [NUM_REQ-1:0]               req_ready,
   input  logic [NUM_REQ-1:0]               req_we,
   input  logic [NUM_REQ-1:0]               req_last,
   input  logic [NUM_REQ-1:0][ADDR_W-1:0]   req_addr,
   input  logic [NUM_REQ-1:0][DATA_W-1:0]   req_wdata,
   output logic [NUM_REQ-1:0]               rsp_valid,
   output logic [DATA_W-1:0]                rsp_rdata,
   output logic                             glb_en,
   output logic                             glb_we,
   output logic [ADDR_W-1:0]                glb_addr,
   output logic [DATA_W-1:0]                glb_wdata,
   input  logic [DATA_W-1:0]                glb_rdata,
   output logic                             idle,
   output state_t                           state_dbg,
   output logic [PTR_W-1:0]                 ptr_dbg
);

   // Handshake: a beat moves in any cycle where req_valid[i] && req_ready[i];
   // req_ready never depends on anything but req_valid, FSM state and rst.

   state_t               state, state_n;
   logic [PTR_W-1:0]     rr_ptr, rr_ptr_n;
   logic [PTR_W-1:0]     owner, owner_n;
   logic [PTR_W-1:0]     sel;
   logic [PTR_W-1:0]     rd_id;
   logic                 rd_pend;
   logic [NUM_REQ-1:0]   pick;
   logic [NUM_REQ-1:0]   owner_mask;

   function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] v);
      if (int'(v) == NUM_REQ - 1) wrap_inc = '0;
      else                        wrap_inc = v + PTR_W'(1);
   endfunction

   rr_arbiter #(
      .N  (NUM_REQ),
      .PW (PTR_W)
   ) u_rr (
      .req (req_valid),
      .ptr (rr_ptr),
      .gnt (pick)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= ST_IDLE;
         rr_ptr  <= '0;
         owner   <= '0;
         rd_pend <= 1'b0;
         rd_id   <= '0;
      end else begin
         state   <= state_n;
         rr_ptr  <= rr_ptr_n;
         owner   <= owner_n;
         rd_pend <= glb_en && !glb_we;
         rd_id   <= sel;
      end
   end

   always_comb begin
      state_n  = state;
      rr_ptr_n = rr_ptr;
      owner_n  = owner;
      case (state)
         ST_IDLE: begin
            if (glb_en) begin
               if (req_last[sel]) begin
                  rr_ptr_n = wrap_inc(sel);
               end else begin
                  state_n = ST_BURST;
                  owner_n = sel;
               end
            end
         end
         ST_BURST: begin
            if (glb_en && req_last[owner]) begin
               state_n  = ST_IDLE;
               rr_ptr_n = wrap_inc(owner);
            end
         end
         default: state_n = ST_IDLE;
      endcase
   end

   // Grants are forced off while rst is high so the GLB sees no access during reset.
   always_comb begin
      owner_mask        = '0;
      owner_mask[owner] = 1'b1;
      req_ready         = '0;
      if (!rst) begin
         if (state == ST_IDLE) req_ready = pick;
         else                  req_ready = owner_mask & req_valid;
      end
      sel = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (req_ready[i]) sel = PTR_W'(i);
      end
      glb_en    = |req_ready;
      glb_we    = glb_en && req_we[sel];
      glb_addr  = req_addr[sel];
      glb_wdata = req_wdata[sel];
      rsp_valid = '0;
      if (rd_pend) rsp_valid[rd_id] = 1'b1;
      rsp_rdata = glb_rdata;
      idle      = (state == ST_IDLE) && !rd_pend;
      state_dbg = state;
      ptr_dbg   = rr_ptr;
   end

endmodule
